// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus by capturing each stable anode/segment pattern once.
// Optional build macro SSEG_DEC_SYNC_EN adds a 2-flop input synchronizer (S=2); without it the pins feed the FSM directly (S=0).
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  AN,
  input  logic [6:0]  sseg,
  input  logic        DP,
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic        digit_wr,
  output logic [2:0]  digit_idx,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  function automatic logic sel_valid(input logic [7:0] an_n);
    logic [7:0] a;
    a = ~an_n;
    return (a != 8'h00) && ((a & (a - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [2:0] sel_index(input logic [7:0] an_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!an_n[i]) idx = 3'(i);
    return idx;
  endfunction

  // {legal, nibble}
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [15:0] pins_w, samp_w;
  assign pins_w = {AN, sseg, DP};

`ifdef SSEG_DEC_SYNC_EN
  logic [15:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pins_w;
      sync2_q <= sync1_q;
    end
  end
  assign samp_w = sync2_q;
`else
  assign samp_w = pins_w;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] prev_q, prev_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  dps_q, dps_d;

  logic [2:0]  cap_idx;
  logic [4:0]  cap_dec;
  logic [7:0]  cap_bit;
  logic        samp_ok;

  assign samp_ok = sel_valid(samp_w[15:8]);
  assign cap_idx = sel_index(prev_q[15:8]);
  assign cap_dec = glyph_decode(prev_q[7:1]);
  assign cap_bit = 8'h01 << cap_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = samp_w;
    mask_d     = mask_q;
    digits_d   = digits_q;
    dps_d      = dps_q;
    digit_wr   = 1'b0;
    digit_idx  = 3'd0;
    frame_done = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (samp_ok) begin
          cnt_d   = 8'd0;
          state_d = (LAST == 8'd0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (!samp_ok) begin
          state_d = IDLE;
        end else begin
          cnt_d = (samp_w != prev_q) ? 8'd0 : cnt_q + 8'd1;
          if (cnt_d == LAST) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Keep the captured pattern as the reference HOLD compares against.
        prev_d  = prev_q;
        state_d = HOLD;
        if (cap_dec[4]) begin
          digit_wr                         = 1'b1;
          digit_idx                        = cap_idx;
          digits_d[{cap_idx, 2'b00} +: 4]  = cap_dec[3:0];
          dps_d[cap_idx]                   = ~prev_q[0];
          if ((mask_q | cap_bit) == 8'hFF) begin
            frame_done = 1'b1;
            mask_d     = 8'h00;
          end else begin
            mask_d = mask_q | cap_bit;
          end
        end else begin
          err = 1'b1;
        end
      end
      HOLD: begin
        if (samp_w != prev_q) begin
          cnt_d = 8'd0;
          if (samp_ok) state_d = (LAST == 8'd0) ? CAPTURE : SETTLE;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      prev_q   <= '1;
      mask_q   <= 8'h00;
      digits_q <= 32'h0;
      dps_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      digits_q <= digits_d;
      dps_q    <= dps_d;
    end
  end

  assign digits = digits_q;
  assign dps    = dps_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scenarios plus randomized scan traffic against a run-length reference model.
module tb_sseg_scan_decoder;

  localparam int SC = 4;
`ifdef SSEG_DEC_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  AN;
  logic [6:0]  sseg;
  logic        DP;
  logic [31:0] digits;
  logic [7:0]  dps;
  logic        digit_wr;
  logic [2:0]  digit_idx;
  logic        frame_done;
  logic        err;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .AN(AN), .sseg(sseg), .DP(DP),
    .digits(digits), .dps(dps), .digit_wr(digit_wr), .digit_idx(digit_idx),
    .frame_done(frame_done), .err(err)
  );

  logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int nvec = 0;
  int nerr = 0;

  // Reference model state: pins seen through an S-deep delay, length of the current run of identical samples.
  logic [15:0] dl [2];
  logic [15:0] last_samp;
  bit          have;
  int          run;
  logic [31:0] m_digits;
  logic [7:0]  m_dps, m_mask;
  bit          pend;
  logic [2:0]  pend_idx;
  logic [3:0]  pend_nib;
  logic        pend_dp;
  logic [7:0]  pend_mask;
  bit          e_wr, e_err, e_frame;
  logic [2:0]  e_idx;

  int wr_cnt, err_cnt, frame_cnt;
  logic [2:0] frame_idx;

  function automatic int glyph_value(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (GLYPH[i] == s) return i;
    return -1;
  endfunction

  function automatic int select_of(input logic [7:0] an);
    int n, pos;
    n = 0;
    pos = -1;
    for (int i = 0; i < 8; i++)
      if (!an[i]) begin
        n++;
        pos = i;
      end
    return (n == 1) ? pos : -1;
  endfunction

  function automatic void model_reset();
    dl[0] = '1;
    dl[1] = '1;
    have = 0;
    run = 0;
    m_digits = 32'h0;
    m_dps = 8'h0;
    m_mask = 8'h0;
    pend = 0;
    e_wr = 0;
    e_err = 0;
    e_frame = 0;
    e_idx = 3'd0;
  endfunction

  function automatic void model_edge(input logic [15:0] p);
    logic [15:0] samp;
    logic [7:0]  nm;
    int sel, g;
    if (pend) begin
      m_digits[pend_idx*4 +: 4] = pend_nib;
      m_dps[pend_idx] = pend_dp;
      m_mask = pend_mask;
    end
    pend = 0;
    if (S == 2) begin
      samp = dl[1];
      dl[1] = dl[0];
      dl[0] = p;
    end else begin
      samp = p;
    end
    if (have && samp == last_samp) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    have = 1;
    last_samp = samp;
    e_wr = 0;
    e_err = 0;
    e_frame = 0;
    e_idx = 3'd0;
    sel = select_of(samp[15:8]);
    if (sel >= 0 && run == SC) begin
      g = glyph_value(samp[7:1]);
      if (g < 0) begin
        e_err = 1;
      end else begin
        e_wr = 1;
        e_idx = 3'(sel);
        pend = 1;
        pend_idx = 3'(sel);
        pend_nib = 4'(g);
        pend_dp = ~samp[0];
        nm = m_mask | (8'h01 << sel);
        if (nm == 8'hFF) begin
          e_frame = 1;
          pend_mask = 8'h00;
        end else begin
          pend_mask = nm;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [7:0] an, input logic [6:0] sg, input logic d);
    AN = an;
    sseg = sg;
    DP = d;
    @(posedge clk);
    model_edge({an, sg, d});
    #1;
    check("digit_wr", {31'h0, digit_wr}, {31'h0, e_wr});
    check("err", {31'h0, err}, {31'h0, e_err});
    check("frame_done", {31'h0, frame_done}, {31'h0, e_frame});
    check("digits", digits, m_digits);
    check("dps", {24'h0, dps}, {24'h0, m_dps});
    if (e_wr) check("digit_idx", {29'h0, digit_idx}, {29'h0, e_idx});
    if (digit_wr === 1'b1) wr_cnt++;
    if (err === 1'b1) err_cnt++;
    if (frame_done === 1'b1) begin
      frame_cnt++;
      frame_idx = digit_idx;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_digits", digits, 32'h0);
    check("rst_dps", {24'h0, dps}, 32'h0);
    check("rst_wr", {31'h0, digit_wr}, 32'h0);
    check("rst_idx", {29'h0, digit_idx}, 32'h0);
    check("rst_frame", {31'h0, frame_done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_cnt = 0;
    err_cnt = 0;
    frame_cnt = 0;
    frame_idx = 3'd0;
  endtask

  initial begin
    logic [7:0]  a, ra;
    logic [6:0]  sg, rs;
    logic        d, rd;
    int          dur;
    int          durs [7] = '{1, 2, 3, 5, 6, 7, 8};

    AN = 8'hFF;
    sseg = 7'h7F;
    DP = 1'b1;
    reset = 1'b0;
    #1;
    do_reset();

    // Single held digit 3 on anode 0 with DP lit.
    repeat (10 + S) tick(8'hFE, 7'h30, 1'b0);
    check("t31_wr_count", wr_cnt, 1);
    check("t31_nibble0", {28'h0, digits[3:0]}, 32'h3);
    check("t31_dp0", {31'h0, dps[0]}, 32'h1);
    check("t31_err_count", err_cnt, 0);

    // Full scan 0..7 completes one frame.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = ~(8'h01 << i);
      repeat (6) tick(a, GLYPH[i], 1'b1);
    end
    repeat (4) tick(8'hFF, 7'h7F, 1'b1);
    check("t32_wr_count", wr_cnt, 8);
    check("t32_frame_count", frame_cnt, 1);
    check("t32_frame_idx", {29'h0, frame_idx}, 32'h7);
    check("t32_digits", digits, 32'h76543210);
    check("t32_dps", {24'h0, dps}, 32'h0);

    // Illegal glyph: one err, nothing written, mask keeps only digit 1.
    do_reset();
    repeat (6) tick(8'hFD, 7'h12, 1'b1);
    repeat (12 + S) tick(8'hFE, 7'h7F, 1'b1);
    check("t33_err_count", err_cnt, 1);
    check("t33_wr_count", wr_cnt, 1);
    check("t33_digits", digits, 32'h00000050);
    for (int i = 0; i < 8; i++) begin
      if (i != 1) begin
        a = ~(8'h01 << i);
        repeat (6) tick(a, GLYPH[9], 1'b1);
      end
    end
    repeat (4) tick(8'hFF, 7'h7F, 1'b1);
    check("t33_frame_count", frame_cnt, 1);
    check("t33_frame_idx", {29'h0, frame_idx}, 32'h7);

    // Ghosting and blanking never capture.
    do_reset();
    repeat (20) tick(8'hFC, 7'h30, 1'b0);
    repeat (6 + S) tick(8'hFF, 7'h30, 1'b0);
    check("t34_wr_count", wr_cnt, 0);
    check("t34_err_count", err_cnt, 0);

    // Segments toggling faster than the window, then held.
    do_reset();
    for (int i = 0; i < 8; i++)
      repeat (3) tick(8'hFB, (i % 2 == 0) ? 7'h30 : 7'h24, 1'b1);
    repeat (SC + S + 2) tick(8'hFB, 7'h79, 1'b1);
    check("t35_wr_count", wr_cnt, 1);
    check("t35_nibble2", {28'h0, digits[11:8]}, 32'h1);

    // Reset with three stable samples seen aborts; a full window is needed afterwards.
    do_reset();
    repeat (S + 3) tick(8'hEF, 7'h19, 1'b0);
    check("t36_pre_wr_count", wr_cnt, 0);
    do_reset();
    check("t36_digits", digits, 32'h0);
    repeat (S + SC - 1) tick(8'hEF, 7'h19, 1'b0);
    check("t36_early_wr_count", wr_cnt, 0);
    repeat (3) tick(8'hEF, 7'h19, 1'b0);
    check("t36_wr_count", wr_cnt, 1);
    check("t36_nibble4", {28'h0, digits[19:16]}, 32'h4);

    // Random scan traffic; durations skip exactly SC so a change never lands on the capture edge.
    do_reset();
    ra = 8'hFF;
    rs = 7'h7F;
    rd = 1'b1;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 9))
        7: a = 8'hFF;
        8, 9: a = 8'($urandom);
        default: a = ~(8'h01 << $urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 5) == 0) sg = 7'($urandom);
      else sg = GLYPH[$urandom_range(0, 15)];
      d = 1'($urandom);
      if ({a, sg, d} == {ra, rs, rd}) d = ~d;
      if ($urandom_range(0, 39) == 0) do_reset();
      dur = durs[$urandom_range(0, 6)];
      repeat (dur) tick(a, sg, d);
      ra = a;
      rs = sg;
      rd = d;
    end
    repeat (S + 3) tick(8'hFF, 7'h7F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
